// File: rtl/key_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encoding, key-code table,
// named codes and auto-repeat intervals.
package key_pkg;

    localparam logic [2:0] ST_SCAN     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_ACCEPT   = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    localparam int RPT_FIRST = 500;
    localparam int RPT_NEXT  = 100;

    // Entry [r*4+c] sits at bits [(r*4+c)*4 +: 4]; row 3 is listed first.
    localparam logic [63:0] KEY_TABLE = {4'hd, KEY_EQ, 4'h0, KEY_CLR,
                                         4'hc, 4'h9, 4'h8, 4'h7,
                                         4'hb, 4'h6, 4'h5, 4'h4,
                                         4'ha, 4'h3, 4'h2, 4'h1};

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        idx = {row, col};
        return KEY_TABLE[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0])      r = 2'd0;
        else if (!rows[1]) r = 2'd1;
        else if (!rows[2]) r = 2'd2;
        else               r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Stable-pattern counter: clr captures the reference pattern; done fires on the
// LIMIT-th consecutive cycle in which the pattern still matches it.
module key_debounce #(
    parameter int LIMIT = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic [3:0] pattern,
    output logic       match,
    output logic       done
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [3:0]    ref_q, ref_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign match = (pattern == ref_q);
    assign done  = match && (cnt_q == LAST);

    always_comb begin
        ref_d = ref_q;
        cnt_d = cnt_q;
        if (clr) begin
            ref_d = pattern;
            cnt_d = '0;
        end else if (!match) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_q <= 4'hF;
            cnt_q <= '0;
        end else begin
            ref_q <= ref_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner with debounce, key-code mapping and a one-cycle flag.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_scan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int COL_DWELL    = 4
) (
    input  logic       CLK_1K,
    input  logic       RSTN,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_value,
    output logic       flag
);
    localparam int DW = $clog2(COL_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);

    logic [3:0]    rs_meta_q, rs_q;
    logic [2:0]    state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    key_value_q, key_value_d;
    logic          db_clr, db_match, db_done;

    key_debounce #(.LIMIT(DEBOUNCE_CYC)) u_debounce (
        .clk     (CLK_1K),
        .rstn    (RSTN),
        .clr     (db_clr),
        .pattern (rs_q),
        .match   (db_match),
        .done    (db_done)
    );

`ifdef KEY_REPEAT_EN
    logic [8:0] rpt_cnt_q, rpt_cnt_d;
    logic       rpt_first_q, rpt_first_d;
    logic       rpt_fire;

    // rpt_cnt_q counts cycles since the last flag; first interval is the long one.
    assign rpt_fire = rpt_first_q ? (rpt_cnt_q >= 9'(RPT_FIRST - 1))
                                  : (rpt_cnt_q >= 9'(RPT_NEXT - 1));

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        if (state_q == ST_ACCEPT)    rpt_cnt_d = 9'd1;
        else if (state_q == ST_HOLD) rpt_cnt_d = rpt_cnt_q + 9'd1;
        if (state_q == ST_DEBOUNCE)                            rpt_first_d = 1'b1;
        else if (state_q == ST_HOLD && state_d == ST_ACCEPT) rpt_first_d = 1'b0;
    end

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            rpt_cnt_q   <= 9'd0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        row_d       = row_q;
        key_value_d = key_value_q;
        db_clr      = 1'b0;
        case (state_q)
            ST_SCAN: begin
                // The synchronizer needs two cycles to show the new column, so only the last dwell cycle is trusted.
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs_q != 4'hF) begin
                        row_d   = low_row(rs_q);
                        db_clr  = 1'b1;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!db_match) begin
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = ST_SCAN;
                end else if (db_done) begin
                    key_value_d = key_lookup(row_q, col_idx_q);
                    state_d     = ST_ACCEPT;
                end
            end
            ST_ACCEPT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (rs_q == 4'hF) begin
                    db_clr  = 1'b1;
                    state_d = ST_RELEASE;
                end
`ifdef KEY_REPEAT_EN
                else if (rpt_fire) begin
                    state_d = ST_ACCEPT;
                end
`endif
            end
            ST_RELEASE: begin
                if (!db_match) begin
                    state_d = ST_HOLD;
                end else if (db_done) begin
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    state_d   = ST_SCAN;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            rs_meta_q   <= 4'hF;
            rs_q        <= 4'hF;
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            row_q       <= 2'd0;
            key_value_q <= 4'h0;
        end else begin
            rs_meta_q   <= row_in;
            rs_q        <= rs_meta_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            key_value_q <= key_value_d;
        end
    end

    assign col_out   = ~(4'b0001 << col_idx_q);
    assign key_value = key_value_q;
    assign flag      = (state_q == ST_ACCEPT);

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan: a keypad model drives row_in from col_out,
// expected key codes are queued at press time and popped on every flag.
module tb_key_scan;
    localparam int DB = 20;
    localparam int CD = 4;

    logic        CLK_1K = 1'b0;
    logic        RSTN;
    logic [3:0]  row_in, col_out, key_value;
    logic        flag;
    logic [15:0] keys;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    key_scan #(.DEBOUNCE_CYC(DB), .COL_DWELL(CD)) dut (
        .CLK_1K    (CLK_1K),
        .RSTN      (RSTN),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_value (key_value),
        .flag      (flag)
    );

    always #5 CLK_1K = ~CLK_1K;

    // Pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK_1K) begin
        if (RSTN === 1'b1 && flag === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_flag: key_value=%0h with no flag expected", key_value);
            end else begin
                check("flag_key_value", {28'd0, key_value}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_1K);
    endtask

    task automatic wait_flag(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK_1K);
            if (flag) begin
                n = k;
                break;
            end
        end
    endtask

    // Returns at the first negedge on which column c is freshly driven (dwell 0).
    task automatic wait_col(input logic [3:0] c, output bit ok);
        int k;
        k = 0;
        while (col_out == c && k < 40) begin @(negedge CLK_1K); k++; end
        while (col_out != c && k < 40) begin @(negedge CLK_1K); k++; end
        ok = (col_out == c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        bit   ok, moved, frozen;
        logic [3:0] ec, first;

        keys = 16'h0;
        RSTN = 1'b1;
        #2 RSTN = 1'b0;
        wait_cyc(3);
        check("reset_col_out", {28'd0, col_out}, 32'he);
        check("reset_flag", {31'd0, flag}, 32'd0);
        check("reset_key_value", {28'd0, key_value}, 32'd0);

        RSTN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ec = ~(4'b0001 << ((i / 4) % 4));
            check("scan_rotation", {28'd0, col_out}, {28'd0, ec});
            @(negedge CLK_1K);
        end

        // Short glitch on row0/col0: never qualifies
        keys[0] = 1'b1;
        wait_cyc(5);
        keys[0] = 1'b0;
        wait_cyc(60);
        check("glitch_key_value", {28'd0, key_value}, 32'd0);
        first = col_out;
        moved = 1'b0;
        repeat (8) begin
            @(negedge CLK_1K);
            if (col_out != first) moved = 1'b1;
        end
        check("glitch_scan_resumes", {31'd0, moved}, 32'd1);

        // Key 6 (row1/col2)
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        wait_flag(45, n);
        check("key6_flag_seen", {31'd0, n > 0}, 32'd1);
        if (n > 0) check("key6_latency", {31'd0, (n + 1 >= DB + 3) && (n + 1 <= DB + 4*CD + 3)}, 32'd1);
        frozen = 1'b1;
        repeat (15) begin
            @(negedge CLK_1K);
            if (col_out != 4'b1011) frozen = 1'b0;
        end
        check("key6_hold_col_frozen", {31'd0, frozen}, 32'd1);
        keys = 16'h0;
        wait_cyc(40);
        check("key6_value_kept", {28'd0, key_value}, 32'h6);

        // Two keys (row3/col2 'e' and row0/col3 'a'), col3 reached first
        wait_col(4'b0111, ok);
        check("multi_a_col_sync", {31'd0, ok}, 32'd1);
        exp_q.push_back(4'ha);
        keys[14] = 1'b1;
        keys[3]  = 1'b1;
        wait_flag(45, n);
        check("multi_a_flag_seen", {31'd0, n > 0}, 32'd1);
        wait_cyc(30);
        check("multi_a_hold_col", {28'd0, col_out}, 32'h7);
        keys = 16'h0;
        wait_cyc(40);

        // Same two keys, col2 reached first
        wait_col(4'b1011, ok);
        check("multi_e_col_sync", {31'd0, ok}, 32'd1);
        exp_q.push_back(4'he);
        keys[14] = 1'b1;
        keys[3]  = 1'b1;
        wait_flag(45, n);
        check("multi_e_flag_seen", {31'd0, n > 0}, 32'd1);
        wait_cyc(30);
        check("multi_e_hold_col", {28'd0, col_out}, 32'hb);
        keys = 16'h0;
        wait_cyc(40);

        // Key 8 (row2/col1) with release bounce: high 10, low 3, high 25+
        exp_q.push_back(4'h8);
        keys[9] = 1'b1;
        wait_flag(45, n);
        check("bounce_flag_seen", {31'd0, n > 0}, 32'd1);
        wait_cyc(10);
        keys = 16'h0;
        wait_cyc(10);
        keys[9] = 1'b1;
        wait_cyc(3);
        keys = 16'h0;
        frozen = 1'b1;
        repeat (20) begin
            @(negedge CLK_1K);
            if (col_out != 4'b1101) frozen = 1'b0;
        end
        check("bounce_col_frozen", {31'd0, frozen}, 32'd1);
        wait_cyc(10);
        check("bounce_scan_resumed", {31'd0, col_out != 4'b1101}, 32'd1);

        // Reset at DEBOUNCE count 10 for key 5 (row1/col1)
        wait_col(4'b1101, ok);
        check("rst_col_sync", {31'd0, ok}, 32'd1);
        keys[5] = 1'b1;
        wait_cyc(13);
        RSTN = 1'b0;
        #1;
        check("rst_mid_col_out", {28'd0, col_out}, 32'he);
        check("rst_mid_flag", {31'd0, flag}, 32'd0);
        check("rst_mid_key_value", {28'd0, key_value}, 32'd0);
        keys = 16'h0;
        wait_cyc(2);
        RSTN = 1'b1;
        wait_cyc(60);

        // Hold key 5 long enough for auto-repeat
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        wait_flag(60, n);
        check("hold5_flag_seen", {31'd0, n > 0}, 32'd1);
`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(4'h5);
        wait_flag(510, n);
        check("repeat_first_gap", n, 32'd500);
        for (int i = 0; i < 3; i++) begin
            wait_flag(110, n);
            check("repeat_next_gap", n, 32'd100);
        end
`else
        wait_cyc(810);
`endif
        keys = 16'h0;
        wait_cyc(40);
        check("pending_flags", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
